pwm_capture: RTL

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module   : pwm_capture
// Desc     : Measures high time and period of an asynchronous PWM input in
//            prescaled ticks, with a signal-loss timeout. Optional 3-sample
//            input glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_capture #(
    parameter int PrescaleDiv  = 99,
    parameter int TimeoutTicks = 1000
) (
    input  logic       c50M,
    input  logic       reset,
    input  logic       PWMin,
    output logic [9:0] highTime,
    output logic [9:0] periodTime,
    output logic       sampleValid,
    output logic       signalLost
);

    localparam int                 c_PRE_W   = (PrescaleDiv > 0) ? $clog2(PrescaleDiv + 1) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PrescaleDiv);
    localparam logic [9:0]         c_CNT_MAX = 10'd1023;
    // A timeout above the counter range can never be reached by a saturating count.
    localparam logic [10:0]        c_TIMEOUT = (TimeoutTicks > 1023) ? 11'd1024 : 11'(TimeoutTicks);

    localparam logic [1:0] c_SEEK = 2'd0;
    localparam logic [1:0] c_HIGH = 2'd1;
    localparam logic [1:0] c_LOW  = 2'd2;

`ifdef PWM_CAPTURE_FILTER_EN
    localparam logic [2:0] c_SETTLE = 3'd6;
`else
    localparam logic [2:0] c_SETTLE = 3'd3;
`endif

    logic                r_sync1;
    logic                r_sync2;
    logic                r_levelDly;
    logic                w_level;
    logic [2:0]          r_settle;
    logic                w_edgeEn;
    logic                w_rise;
    logic                w_fall;
    logic [c_PRE_W-1:0]  r_pre;
    logic                w_tick;
    logic [1:0]          r_state;
    logic [9:0]          r_highCnt;
    logic [9:0]          r_periodCnt;
    logic [9:0]          w_highInc;
    logic [9:0]          w_periodInc;
    logic                w_timeout;
    logic [9:0]          r_highTime;
    logic [9:0]          r_periodTime;
    logic                r_sampleValid;
    logic                r_signalLost;

    always_ff @(posedge c50M) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= PWMin;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic [1:0] r_hist;
    logic       r_filt;

    always_ff @(posedge c50M) begin
        if (reset) begin
            r_hist <= 2'b00;
            r_filt <= 1'b0;
        end else begin
            r_hist <= {r_hist[0], r_sync2};
            if ({r_hist, r_sync2} == 3'b111) begin
                r_filt <= 1'b1;
            end else if ({r_hist, r_sync2} == 3'b000) begin
                r_filt <= 1'b0;
            end
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    // Edges are masked until the input pipeline has refilled after reset, so the
    // reset-value-to-live-level transition is never mistaken for a real edge.
    always_ff @(posedge c50M) begin
        if (reset) begin
            r_settle   <= 3'd0;
            r_levelDly <= 1'b0;
        end else begin
            r_levelDly <= w_level;
            if (r_settle != c_SETTLE) begin
                r_settle <= r_settle + 3'd1;
            end
        end
    end

    assign w_edgeEn = (r_settle == c_SETTLE);
    assign w_rise   = w_edgeEn &  w_level & ~r_levelDly;
    assign w_fall   = w_edgeEn & ~w_level &  r_levelDly;

    assign w_tick = (r_pre == c_PRE_MAX);

    always_ff @(posedge c50M) begin
        if (reset) begin
            r_pre <= '0;
        end else if (w_rise || w_tick) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + c_PRE_W'(1);
        end
    end

    assign w_highInc   = (r_highCnt   == c_CNT_MAX) ? r_highCnt   : r_highCnt   + 10'd1;
    assign w_periodInc = (r_periodCnt == c_CNT_MAX) ? r_periodCnt : r_periodCnt + 10'd1;
    assign w_timeout   = ({1'b0, w_periodInc} >= c_TIMEOUT);

    // Edge handling is checked before the tick in every state, so a tick that
    // coincides with an edge is dropped.
    always_ff @(posedge c50M) begin
        if (reset) begin
            r_state       <= c_SEEK;
            r_highCnt     <= 10'd0;
            r_periodCnt   <= 10'd0;
            r_highTime    <= 10'd0;
            r_periodTime  <= 10'd0;
            r_sampleValid <= 1'b0;
            r_signalLost  <= 1'b0;
        end else begin
            r_sampleValid <= 1'b0;
            case (r_state)
                c_SEEK: begin
                    if (w_rise) begin
                        r_state     <= c_HIGH;
                        r_highCnt   <= 10'd0;
                        r_periodCnt <= 10'd0;
                    end
                end
                c_HIGH: begin
                    if (w_fall) begin
                        r_state <= c_LOW;
                    end else if (w_tick) begin
                        if (w_timeout) begin
                            r_state      <= c_SEEK;
                            r_signalLost <= 1'b1;
                            r_highTime   <= 10'd0;
                            r_periodTime <= 10'd0;
                        end else begin
                            r_highCnt   <= w_highInc;
                            r_periodCnt <= w_periodInc;
                        end
                    end
                end
                c_LOW: begin
                    if (w_rise) begin
                        r_state       <= c_HIGH;
                        r_highTime    <= r_highCnt;
                        r_periodTime  <= r_periodCnt;
                        r_sampleValid <= 1'b1;
                        r_signalLost  <= 1'b0;
                        r_highCnt     <= 10'd0;
                        r_periodCnt   <= 10'd0;
                    end else if (w_tick) begin
                        if (w_timeout) begin
                            r_state      <= c_SEEK;
                            r_signalLost <= 1'b1;
                            r_highTime   <= 10'd0;
                            r_periodTime <= 10'd0;
                        end else begin
                            r_periodCnt <= w_periodInc;
                        end
                    end
                end
                default: begin
                    r_state <= c_SEEK;
                end
            endcase
        end
    end

    assign highTime    = r_highTime;
    assign periodTime  = r_periodTime;
    assign sampleValid = r_sampleValid;
    assign signalLost  = r_signalLost;

endmodule
`default_nettype wire
